regfile_2r1w: RTL and testbench

//  Parametrised storage bank: DEPTH words of WIDTH bits, one write port with byte enables,
//  two independent read ports with registered (1-cycle) outputs and complement outputs.

---
 rtl/rf_pkg.sv | 25 ++
 rtl/rf_read_port.sv | 44 ++++
 rtl/regfile_2r1w.sv | 85 ++++++++
 tb/tb_regfile_2r1w.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the regfile_2r1w storage bank.
// Width-generic helpers operate on MAX_W-bit vectors; callers size-cast in and out.
package rf_pkg;

    localparam int BYTE_W   = 8;
    localparam int MAX_W    = 1024;
    localparam int MAX_BE_W = MAX_W / BYTE_W;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]    old_word,
                                                  input logic [MAX_W-1:0]    new_word,
                                                  input logic [MAX_BE_W-1:0] be);
        logic [MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: 1-cycle latency, holds data when idle, zero for
// out-of-range addresses, optional same-edge write bypass selected by the top.
module rf_read_port
    import rf_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    input  logic              byp_hit,
    input  logic [WIDTH-1:0]  byp_word,
    output logic [WIDTH-1:0]  rdata,
    output logic [WIDTH-1:0]  rdata_n,
    output logic              rvalid
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic rd_ok;
    assign rd_ok = ({1'b0, raddr} < DEPTH_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                if (byp_hit)    rdata <= byp_word;
                else if (rd_ok) rdata <= mem[raddr];
                else            rdata <= '0;
            end
        end
    end

    // Derived combinationally so it can never disagree with rdata, reset included.
    assign rdata_n = ~rdata;

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: one byte-enabled write port, two registered read ports.
// Build option RF_BYPASS_EN: same-edge read of the write address returns the post-write word.
module regfile_2r1w
    import rf_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = addr_w(DEPTH),
    localparam int BE_W   = WIDTH / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic              re0,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata0_n,
    output logic              rvalid0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata1_n,
    output logic              rvalid1
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] wr_word;
    logic             wr_ok;
    logic             hit0;
    logic             hit1;

    assign wr_ok   = we && ({1'b0, waddr} < DEPTH_V);
    assign wr_word = wr_ok ? WIDTH'(be_merge(MAX_W'(mem[waddr]), MAX_W'(wdata), MAX_BE_W'(wbe)))
                           : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wr_word;
        end
    end

    // Without bypass the ports sample mem before this edge's write lands.
    assign hit0 = BYPASS && wr_ok && (raddr0 == waddr);
    assign hit1 = BYPASS && wr_ok && (raddr1 == waddr);

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .re       (re0),
        .raddr    (raddr0),
        .mem      (mem),
        .byp_hit  (hit0),
        .byp_word (wr_word),
        .rdata    (rdata0),
        .rdata_n  (rdata0_n),
        .rvalid   (rvalid0)
    );

    rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .re       (re1),
        .raddr    (raddr1),
        .mem      (mem),
        .byp_hit  (hit1),
        .byp_word (wr_word),
        .rdata    (rdata1),
        .rdata_n  (rdata1_n),
        .rvalid   (rvalid1)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed cases plus random traffic against
// an array model; a second DEPTH=12 instance covers out-of-range addressing.
module tb_regfile_2r1w;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        re0 = 1'b0, re1 = 1'b0;
    logic [3:0]  raddr0 = '0, raddr1 = '0;
    logic [31:0] rdata0, rdata0_n, rdata1, rdata1_n;
    logic        rvalid0, rvalid1;

    logic        d_we = 1'b0;
    logic [3:0]  d_waddr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wbe = '0;
    logic        d_re0 = 1'b0, d_re1 = 1'b0;
    logic [3:0]  d_raddr0 = '0, d_raddr1 = '0;
    logic [31:0] d_rdata0, d_rdata0_n, d_rdata1, d_rdata1_n;
    logic        d_rvalid0, d_rvalid1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [16];
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
    logic        exp_v0 = 1'b0, exp_v1 = 1'b0;

    always #5 clk = ~clk;

    regfile_2r1w dut (
        .clk(clk), .rst_n(rst_n),
        .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re0(re0), .raddr0(raddr0), .rdata0(rdata0), .rdata0_n(rdata0_n), .rvalid0(rvalid0),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rdata1_n(rdata1_n), .rvalid1(rvalid1)
    );

    regfile_2r1w #(.WIDTH(32), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .we(d_we), .waddr(d_waddr), .wdata(d_wdata), .wbe(d_wbe),
        .re0(d_re0), .raddr0(d_raddr0), .rdata0(d_rdata0), .rdata0_n(d_rdata0_n), .rvalid0(d_rvalid0),
        .re1(d_re1), .raddr1(d_raddr1), .rdata1(d_rdata1), .rdata1_n(d_rdata1_n), .rvalid1(d_rvalid1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        exp_v0  = 1'b0;
        exp_v1  = 1'b0;
    endtask

    // Predict from the model, take one edge, then compare every main-DUT output.
    task automatic step();
        logic [31:0] merged;
        merged = model_mem[waddr];
        for (int b = 0; b < 4; b++)
            if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        if (re0) exp_rd0 = (BYP && we && raddr0 == waddr) ? merged : model_mem[raddr0];
        if (re1) exp_rd1 = (BYP && we && raddr1 == waddr) ? merged : model_mem[raddr1];
        exp_v0 = re0;
        exp_v1 = re1;
        if (we) model_mem[waddr] = merged;
        @(posedge clk);
        #1;
        chk("rdata0",   rdata0,   exp_rd0);
        chk("rdata0_n", rdata0_n, ~exp_rd0);
        chk("rvalid0",  {31'b0, rvalid0}, {31'b0, exp_v0});
        chk("rdata1",   rdata1,   exp_rd1);
        chk("rdata1_n", rdata1_n, ~exp_rd1);
        chk("rvalid1",  {31'b0, rvalid1}, {31'b0, exp_v1});
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic r0, input logic [3:0] a0,
                         input logic r1, input logic [3:0] a1);
        we = w; waddr = wa; wdata = wd; wbe = be;
        re0 = r0; raddr0 = a0; re1 = r1; raddr1 = a1;
        step();
    endtask

    task automatic d12_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rdata0",   rdata0,   32'h0);
        chk("rst_rdata0_n", rdata0_n, 32'hFFFF_FFFF);
        chk("rst_rdata1",   rdata1,   32'h0);
        chk("rst_rvalid0",  {31'b0, rvalid0}, 32'h0);
        chk("rst_rvalid1",  {31'b0, rvalid1}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 1, 4'(a), 1, 4'(15 - a));
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int a = 0; a < 16; a++) drive(1, 4'(a), 32'hA5A5_0000 + a, 4'hF, 0, 0, 0, 0);
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 1, 4'(a), 1, 4'(15 - a));
            chk("full_p0", rdata0, 32'hA5A5_0000 + a);
            chk("full_p1", rdata1, 32'hA5A5_0000 + (15 - a));
        end

        drive(1, 3, 32'h1122_3344, 4'hF, 0, 0, 0, 0);
        drive(1, 3, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 1, 3);
        chk("byte_en", rdata0, 32'h11BB_33DD);
        chk("same_addr", rdata1, rdata0);
        drive(1, 3, 32'hFFFF_FFFF, 4'h0, 1, 3, 0, 0);
        chk("wbe_zero", rdata0, 32'h11BB_33DD);

        drive(1, 5, 32'h0, 4'hF, 0, 0, 0, 0);
        drive(1, 5, 32'hDEAD_BEEF, 4'hF, 1, 5, 0, 0);
        chk("collide", rdata0, BYP ? 32'hDEAD_BEEF : 32'h0);
        drive(0, 0, 0, 0, 1, 5, 0, 0);
        chk("collide_after", rdata0, 32'hDEAD_BEEF);

        drive(1, 7, 32'h1234, 4'hF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, $urandom, 4'hF, 0, 0, 1, 7);
            chk("hold_data",  rdata0, 32'h1234);
            chk("hold_valid", {31'b0, rvalid0}, 32'h0);
        end

        for (int i = 0; i < 400; i++)
            drive(1'($urandom), 4'($urandom), $urandom, 4'($urandom),
                  1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));

        we = 1'b1; waddr = 9; wdata = 32'hCAFE_F00D; wbe = 4'hF;
        re0 = 1'b1; raddr0 = 9; re1 = 1'b1; raddr1 = 2;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata0",   rdata0,   32'h0);
        chk("mid_rst_rdata0_n", rdata0_n, 32'hFFFF_FFFF);
        chk("mid_rst_rdata1",   rdata1,   32'h0);
        chk("mid_rst_rvalid0",  {31'b0, rvalid0}, 32'h0);
        chk("mid_rst_rvalid1",  {31'b0, rvalid1}, 32'h0);
        @(posedge clk);
        #1;
        chk("in_rst_rvalid0", {31'b0, rvalid0}, 32'h0);
        model_reset();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) drive(0, 0, 0, 0, 1, 4'(a), 1, 4'(15 - a));

        d_we = 1'b1; d_waddr = 11; d_wdata = 32'h0000_5A5A; d_wbe = 4'hF;
        d12_step();
        d_waddr = 13; d_wdata = 32'hFFFF_FFFF;
        d12_step();
        d_we = 1'b0;
        for (int a = 0; a < 12; a++) begin
            d_re0 = 1'b1; d_raddr0 = 4'(a);
            d_re1 = 1'b1; d_raddr1 = 13;
            d12_step();
            chk("d12_word", d_rdata0, (a == 11) ? 32'h0000_5A5A : 32'h0);
            chk("d12_oob_data", d_rdata1, 32'h0);
            chk("d12_oob_valid", {31'b0, d_rvalid1}, 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
